// File: rtl/vp_key_sched.sv
// vp_key_sched: serialises PS/2 key events and gamepad numpad buttons into one
// gap-spaced event stream for vp_keymap. Joystick path compiled in with VP_KEYSCHED_JOY_EN.
module vp_key_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       ps2_valid_i,
  input  logic [7:0] ps2_ascii_i,
  input  logic       ps2_released_i,
  input  logic [9:0] joy_numpad_i,
  output logic       key_valid_o,
  output logic [7:0] key_ascii_o,
  output logic       key_released_o,
  output logic       busy_o,
  output logic       overflow_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic          grant_joy;
  logic          rr_joy;

  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  logic          push_req;
  logic          full;
  logic          push;
  logic          pop;
  logic          ps2_pend;
  logic          joy_pend;
  logic [7:0]    joy_ascii;
  logic          joy_rel;

  assign push_req = ps2_valid_i && (ps2_ascii_i != 8'h00);
  assign full     = (fifo_cnt == FIFO_FULL);
  assign pop      = (state == ISSUE) && !grant_joy;
  assign push     = push_req && (!full || pop);
  assign ps2_pend = (fifo_cnt != '0);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; fifo_cnt alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {ps2_ascii_i, ps2_released_i};
  end

`ifdef VP_KEYSCHED_JOY_EN
  logic [9:0] joy_q;
  logic [9:0] rise;
  logic [9:0] fall;
  logic [9:0] press_pend;
  logic [9:0] rel_pend;
  logic [9:0] clr_vec;
  logic [3:0] sel_idx;

  assign rise     = joy_numpad_i & ~joy_q;
  assign fall     = ~joy_numpad_i & joy_q;
  assign joy_pend = |(press_pend | rel_pend);

  // Lowest pending key wins; a pending press goes out before its release.
  always_comb begin
    sel_idx = 4'd0;
    joy_rel = 1'b0;
    for (int i = 9; i >= 0; i--) begin
      if (press_pend[i] || rel_pend[i]) begin
        sel_idx = 4'(i);
        joy_rel = !press_pend[i];
      end
    end
  end

  assign joy_ascii = (sel_idx == 4'd9) ? 8'h30 : 8'h31 + {4'b0000, sel_idx};
  assign clr_vec   = (state == ISSUE && grant_joy) ? (10'd1 << sel_idx) : 10'd0;

  // New edges are applied after the issue clear so a fresh edge is never lost.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      joy_q      <= '0;
      press_pend <= '0;
      rel_pend   <= '0;
    end else begin
      joy_q      <= joy_numpad_i;
      press_pend <= (press_pend & ~(clr_vec & {10{!joy_rel}})) | rise;
      rel_pend   <= (rel_pend & ~(clr_vec & {10{joy_rel}}) & ~rise) | fall;
    end
  end
`else
  logic unused_joy;
  assign unused_joy = ^joy_numpad_i;
  assign joy_pend   = 1'b0;
  assign joy_ascii  = 8'h00;
  assign joy_rel    = 1'b0;
`endif

  assign busy_o = (state != IDLE) || ps2_pend || joy_pend;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      grant_joy      <= 1'b0;
      rr_joy         <= 1'b0;
      key_valid_o    <= 1'b0;
      key_ascii_o    <= 8'h00;
      key_released_o <= 1'b0;
      overflow_o     <= 1'b0;
    end else begin
      key_valid_o <= 1'b0;
      if (push_req && full && !pop) overflow_o <= 1'b1;

      case (state)
        IDLE: begin
          // The round-robin pointer only moves when both sources contend.
          if (ps2_pend && joy_pend) begin
            grant_joy <= rr_joy;
            rr_joy    <= !rr_joy;
            state     <= ISSUE;
          end else if (ps2_pend || joy_pend) begin
            grant_joy <= joy_pend;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          key_valid_o <= 1'b1;
          if (grant_joy) begin
            key_ascii_o    <= joy_ascii;
            key_released_o <= joy_rel;
          end else begin
            {key_ascii_o, key_released_o} <= fifo_mem[rd_ptr];
          end
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
